// File: rtl/tape_pkg.sv
// Shared state encoding and CPC tape timing defaults
// for the cassette pulse generator.
package tape_pkg;

  localparam int TW = 16;

  typedef enum logic [2:0] {
    IDLE,
    PILOT,
    SYNC1,
    SYNC2,
    DATA,
    TAIL
  } tape_state_e;

  // Standard CPC block timings in 4 MHz ce ticks
  localparam int DEF_PILOT_T   = 2000;
  localparam int DEF_SYNC_T    = 600;
  localparam int DEF_ZERO_T    = 667;
  localparam int DEF_ONE_T     = 1333;
  localparam int DEF_PILOT_LEN = 4096;

endpackage

// File: rtl/tape_pulse_timer.sv
// Pulse-length down-counter with gated decrement,
// expiry strobe and output level toggle.
module tape_pulse_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          run_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          toggle_en_i,
  output logic          expire_o,
  output logic          level_o
);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  assign expire_o = run_i && (cnt_q == '0);
  assign level_o  = level_q;

  // A reload on expiry wins over the decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (run_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign level_d = level_q ^ (expire_o & toggle_en_i);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/tape_pulse_gen.sv
// CPC cassette signal generator: pilot, two sync
// pulses, then PWM data bits pulled from a byte stream.
module tape_pulse_gen #(
  parameter int TAIL_TICKS = 4000,
  parameter int TW         = tape_pkg::TW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          motor,
  input  logic          start,
  input  logic [TW-1:0] pilot_len,
  input  logic [TW-1:0] pilot_t,
  input  logic [TW-1:0] sync1_t,
  input  logic [TW-1:0] sync2_t,
  input  logic [TW-1:0] zero_t,
  input  logic [TW-1:0] one_t,
  input  logic [7:0]    din,
  input  logic          din_valid,
  input  logic          din_last,
  output logic          din_ready,
  output logic          tape_out,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  import tape_pkg::*;

  localparam logic [TW-1:0] TAIL_M1 = TW'(TAIL_TICKS - 1);

  function automatic logic [TW-1:0] m1(
    input logic [TW-1:0] len
  );
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  tape_state_e   state_q, state_d;
  logic [TW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] pt_q, pt_d;
  logic [TW-1:0] s1_q, s1_d;
  logic [TW-1:0] s2_q, s2_d;
  logic [TW-1:0] z_q, z_d;
  logic [TW-1:0] o_q, o_d;
  logic [7:0]    byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic          half_q, half_d;
  logic          last_q, last_d;
  logic          wait_q, wait_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          und_q, und_d;

  logic          run, expire, load, need;
  logic [TW-1:0] load_val;
  logic [TW-1:0] bit_len, nxt_len;

  assign run = ce & motor & ~wait_q
             & (state_q != IDLE);

  assign bit_len = byte_q[bit_q] ? o_q : z_q;
  assign nxt_len = byte_q[bit_q - 3'd1]
                 ? o_q : z_q;

  tape_pulse_timer #(
    .TW(TW)
  ) u_timer (
    .clk        (clk),
    .rst_ni     (reset_n),
    .run_i      (run),
    .load_i     (load),
    .load_val_i (load_val),
    .toggle_en_i(state_q != TAIL),
    .expire_o   (expire),
    .level_o    (tape_out)
  );

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    pt_d      = pt_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    z_d       = z_q;
    o_d       = o_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    half_d    = half_q;
    last_d    = last_q;
    wait_d    = wait_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    und_d     = und_q;
    need      = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    din_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          pt_d   = pilot_t;
          s1_d   = sync1_t;
          s2_d   = sync2_t;
          z_d    = zero_t;
          o_d    = one_t;
          pcnt_d = pilot_len;
          busy_d = 1'b1;
          und_d  = 1'b0;
          load   = 1'b1;
          if (pilot_len == '0) begin
            state_d  = SYNC1;
            load_val = m1(sync1_t);
          end else begin
            state_d  = PILOT;
            load_val = m1(pilot_t);
          end
        end
      end
      PILOT: begin
        if (expire) begin
          load = 1'b1;
          if (pcnt_q <= TW'(1)) begin
            state_d  = SYNC1;
            load_val = m1(s1_q);
          end else begin
            pcnt_d   = pcnt_q - 1'b1;
            load_val = m1(pt_q);
          end
        end
      end
      SYNC1: begin
        if (expire) begin
          state_d  = SYNC2;
          load     = 1'b1;
          load_val = m1(s2_q);
        end
      end
      SYNC2: begin
        if (expire) begin
          state_d = DATA;
          need    = 1'b1;
        end
      end
      DATA: begin
        if (expire) begin
          if (!half_q) begin
            half_d   = 1'b1;
            load     = 1'b1;
            load_val = m1(bit_len);
          end else if (bit_q != '0) begin
            bit_d    = bit_q - 3'd1;
            half_d   = 1'b0;
            load     = 1'b1;
            load_val = m1(nxt_len);
          end else if (last_q) begin
            state_d  = TAIL;
            load     = 1'b1;
            load_val = TAIL_M1;
          end else begin
            need = 1'b1;
          end
        end
      end
      TAIL: begin
        if (expire) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A starved fetch parks the timer until a byte arrives
    if (need || wait_q) begin
      if (din_valid) begin
        din_ready = 1'b1;
        byte_d    = din;
        last_d    = din_last;
        bit_d     = 3'd7;
        half_d    = 1'b0;
        wait_d    = 1'b0;
        load      = 1'b1;
        load_val  = m1(din[7] ? o_q : z_q);
      end else begin
        wait_d = 1'b1;
        und_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      pt_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      z_q     <= '0;
      o_q     <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      last_q  <= 1'b0;
      wait_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      pt_q    <= pt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      z_q     <= z_d;
      o_q     <= o_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      und_q   <= und_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_tape_pulse_gen.sv
// Bench for tape_pulse_gen: edge-interval model
// driven from block config and byte list.
`timescale 1ns/1ps
module tb_tape_pulse_gen;

  localparam int TAIL = 40;
  localparam int TW   = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce = 1'b1;
  logic          motor = 1'b1;
  logic          start = 1'b0;
  logic [TW-1:0] pilot_len = '0;
  logic [TW-1:0] pilot_t = '0;
  logic [TW-1:0] sync1_t = '0;
  logic [TW-1:0] sync2_t = '0;
  logic [TW-1:0] zero_t = '0;
  logic [TW-1:0] one_t = '0;
  logic [7:0]    din = '0;
  logic          din_valid = 1'b0;
  logic          din_last = 1'b0;
  logic          din_ready, tape_out;
  logic          busy, done, underrun;

  int checks = 0;
  int errors = 0;

  int   exp_q[$];
  int   civ_log[$];
  bit   tail = 0, blk_active = 0, mon_en = 0;
  bit   start_acc = 0, ref_pend = 0, civ_pend = 0;
  bit   rdy_seen = 0, und_seen = 0;
  int   cnt = 0, civ = 0, blk_edges = 0;
  logic prev_t = 1'b0;

  logic [7:0] fbytes[8];
  int   fn = 0, fidx = 0, need_base = 0;
  int   stall_idx = -1, stall_left = 0;
  bit   fload = 0;

  tape_pulse_gen #(
    .TAIL_TICKS(TAIL),
    .TW(TW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .motor    (motor),
    .start    (start),
    .pilot_len(pilot_len),
    .pilot_t  (pilot_t),
    .sync1_t  (sync1_t),
    .sync2_t  (sync2_t),
    .zero_t   (zero_t),
    .one_t    (one_t),
    .din      (din),
    .din_valid(din_valid),
    .din_last (din_last),
    .din_ready(din_ready),
    .tape_out (tape_out),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int eff(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  // Expected pulse lengths of a whole block, in ce ticks
  task automatic plan(input int pl, input int pt,
                      input int s1, input int s2,
                      input int z, input int o);
    exp_q.delete();
    for (int i = 0; i < pl; i++) exp_q.push_back(eff(pt));
    exp_q.push_back(eff(s1));
    exp_q.push_back(eff(s2));
    for (int k = 0; k < fn; k++) begin
      for (int b = 7; b >= 0; b--) begin
        int l;
        l = fbytes[k][b] ? eff(o) : eff(z);
        exp_q.push_back(l);
        exp_q.push_back(l);
      end
    end
  endtask

  task automatic go(input int pl, input int pt,
                    input int s1, input int s2,
                    input int z, input int o);
    @(posedge clk); #1;
    pilot_len = TW'(pl);
    pilot_t   = TW'(pt);
    sync1_t   = TW'(s1);
    sync2_t   = TW'(s2);
    zero_t    = TW'(z);
    one_t     = TW'(o);
    start     = 1'b1;
    start_acc = 1'b1;
    plan(pl, pt, s1, s2, z, o);
    blk_edges = 0;
    need_base = pl + 2;
    und_seen  = 0;
    civ_log.delete();
    @(posedge clk); #1;
    start     = 1'b0;
    start_acc = 1'b0;
    pilot_len = 16'd9;
    pilot_t   = 16'd13;
    sync1_t   = 16'd11;
    sync2_t   = 16'd12;
    zero_t    = 16'd7;
    one_t     = 16'd8;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((blk_active || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < budget, nm, n, budget);
  endtask

  // Observer: interval per edge in ce ticks, done/busy per cycle
  always @(negedge clk) begin
    bit tog, dexp;
    int e;
    rdy_seen = din_ready;
    if (!mon_en) begin
      prev_t   = tape_out;
      cnt      = 0;
      civ      = 0;
      ref_pend = 0;
      civ_pend = 0;
    end else begin
      tog = (tape_out !== prev_t);
      civ++;
      if (tog) begin
        prev_t = tape_out;
        blk_edges++;
        civ_log.push_back(civ);
        civ = 0;
        chk(exp_q.size() != 0, "edge_expected", blk_edges, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(cnt == e, "edge_interval", cnt, e);
          if (exp_q.size() == 0) tail = 1;
        end
      end
      if (tog || ref_pend) cnt = 0;
      if (civ_pend) begin
        civ = 0;
        blk_active = 1;
      end
      dexp = tail && (cnt == TAIL);
      if (dexp) begin
        tail = 0;
        blk_active = 0;
      end
      chk(done === dexp, "done", int'(done), int'(dexp));
      chk(busy === blk_active, "busy", int'(busy), int'(blk_active));
      if (underrun === 1'b1) und_seen = 1;
      ref_pend = din_ready || (start && start_acc);
      civ_pend = start && start_acc;
      if (ce && motor) cnt++;
    end
  end

  // Byte source, optionally starved once a given byte is needed
  initial begin
    forever begin
      @(posedge clk); #1;
      if (fload) begin
        fidx  = 0;
        fload = 0;
      end else if (rdy_seen) begin
        fidx++;
      end
      if (fidx == stall_idx && stall_left > 0 &&
          blk_edges >= need_base + 16 * fidx)
        stall_left--;
      din       = (fidx < fn) ? fbytes[fidx] : 8'h00;
      din_last  = (fidx == fn - 1);
      din_valid = (fidx < fn) &&
                  !(fidx == stall_idx && stall_left > 0);
    end
  end

  initial begin
    int lit1[22];
    int n;
    lit1 = '{10, 10, 10, 10, 3, 5,
             4, 4, 2, 2, 4, 4, 2, 2,
             2, 2, 4, 4, 2, 2, 4, 4};

    repeat (3) @(posedge clk);
    #1;
    chk(tape_out === 1'b0, "rst_tape", int'(tape_out), 0);
    chk(busy === 1'b0, "rst_busy", int'(busy), 0);
    chk(done === 1'b0, "rst_done", int'(done), 0);
    chk(din_ready === 1'b0, "rst_ready", int'(din_ready), 0);
    chk(underrun === 1'b0, "rst_underrun", int'(underrun), 0);
    reset_n = 1'b1;
    mon_en  = 1;

    // Basic block, one byte 0xA5
    fbytes[0] = 8'hA5; fn = 1; fload = 1;
    plan(4, 10, 3, 5, 2, 4);
    for (int i = 0; i < 22; i++)
      chk(exp_q[i] == lit1[i], "model_pin", exp_q[i], lit1[i]);
    go(4, 10, 3, 5, 2, 4);
    wait_idle(2000, "t1_timeout");
    chk(civ_log.size() == 22, "t1_edges", civ_log.size(), 22);
    for (int i = 0; i < 22 && i < civ_log.size(); i++)
      chk(civ_log[i] == lit1[i], "t1_clk_interval", civ_log[i], lit1[i]);
    chk(underrun === 1'b0, "t1_underrun", int'(underrun), 0);

    // Motor gap inside the pilot
    fbytes[0] = 8'hA5; fn = 1; fload = 1;
    go(4, 10, 3, 5, 2, 4);
    repeat (15) @(posedge clk);
    #1; motor = 1'b0;
    repeat (50) @(posedge clk);
    #1; motor = 1'b1;
    wait_idle(2000, "t2_timeout");
    chk(civ_log.size() > 1 && civ_log[1] == 60, "t2_gap_interval",
        civ_log.size() > 1 ? civ_log[1] : -1, 60);
    chk(blk_edges == 22, "t2_edges", blk_edges, 22);

    // Starved second byte
    fbytes[0] = 8'h3C; fbytes[1] = 8'h81; fn = 2; fload = 1;
    stall_idx = 1; stall_left = 20;
    go(4, 10, 3, 5, 2, 4);
    wait_idle(3000, "t3_timeout");
    chk(und_seen == 1, "t3_underrun_seen", int'(und_seen), 1);
    chk(underrun === 1'b1, "t3_underrun_sticky", int'(underrun), 1);
    chk(civ_log.size() > 22 && civ_log[22] >= 24, "t3_stall_gap",
        civ_log.size() > 22 ? civ_log[22] : -1, 24);
    chk(blk_edges == 38, "t3_edges", blk_edges, 38);
    stall_idx = -1;

    // Start while busy, start in the done clk, then a fresh block
    fbytes[0] = 8'h5A; fn = 1; fload = 1;
    go(2, 6, 3, 4, 1, 3);
    chk(underrun === 1'b0, "t4_underrun_clr", int'(underrun), 1'b0);
    repeat (5) @(posedge clk);
    #1; pilot_t = 16'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(done === 1'b1, "t4_done_seen", int'(done), 1);
    pilot_len = 16'd1; pilot_t = 16'd9; start = 1'b1;
    fbytes[0] = 8'hC3; fn = 1; fload = 1;
    go(3, 5, 2, 2, 3, 1);
    wait_idle(2000, "t4_timeout");
    chk(civ_log.size() > 0 && civ_log[0] == 5, "t4_fresh_pilot",
        civ_log.size() > 0 ? civ_log[0] : -1, 5);
    chk(blk_edges == 21, "t4_edges", blk_edges, 21);

    // Asynchronous reset in the middle of DATA
    fbytes[0] = 8'hFF; fbytes[1] = 8'h00; fbytes[2] = 8'h55;
    fn = 3; fload = 1;
    go(4, 10, 3, 5, 2, 4);
    n = 0;
    while (!(blk_edges >= 9 && tape_out === 1'b1) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < 2000, "t5_reach_data", n, 2000);
    @(negedge clk);
    #2;
    mon_en = 0;
    reset_n = 1'b0;
    #1;
    chk(tape_out === 1'b0, "t5_rst_tape", int'(tape_out), 0);
    chk(busy === 1'b0, "t5_rst_busy", int'(busy), 0);
    chk(din_ready === 1'b0, "t5_rst_ready", int'(din_ready), 0);
    exp_q.delete();
    tail = 0;
    blk_active = 0;
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    mon_en = 1;

    // No pilot, zero_t of 0
    fbytes[0] = 8'h0F; fn = 1; fload = 1;
    go(0, 8, 3, 2, 0, 2);
    wait_idle(2000, "t6_timeout");
    chk(civ_log.size() > 0 && civ_log[0] == 3, "t6_first_edge",
        civ_log.size() > 0 ? civ_log[0] : -1, 3);
    chk(civ_log.size() > 2 && civ_log[2] == 1, "t6_zero_pulse",
        civ_log.size() > 2 ? civ_log[2] : -1, 1);
    chk(blk_edges == 18, "t6_edges", blk_edges, 18);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tape_pulse_gen.md
Name: tape_pulse_gen

Overview:
Cassette-signal generator that drives the motherboard's tape_in from a byte stream, producing CPC-format tape audio: pilot tone, two sync pulses, then PWM-coded data bits. It gates on the motherboard's tape_motor output and pulls bytes from a loader/DDRAM reader through a valid/ready handshake. It sits between the file loader and the motherboard, and is the transmitter for the CPC ROM tape reader.

Parameters:
TAIL_TICKS, 4000, ce ticks the level is held after the last data pulse before done (1 ms at 4 MHz).
TW, 16, width of all pulse-length fields, in ce ticks.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
ce  in  1  timing enable, one clk wide (4 MHz, phi_en_n rate)
motor  in  1  tape motor; 0 freezes generation
start  in  1  one-clk pulse; latches config and begins a block
pilot_len  in  TW  number of pilot pulses
pilot_t  in  TW  pilot pulse length
sync1_t  in  TW  first sync pulse length
sync2_t  in  TW  second sync pulse length
zero_t  in  TW  pulse length for a 0 bit
one_t  in  TW  pulse length for a 1 bit
din  in  8  data byte
din_valid  in  1  din holds a byte
din_last  in  1  qualifies din as the final byte of the block
din_ready  out  1  byte accepted this clk
tape_out  out  1  signal level to motherboard tape_in
busy  out  1  block in progress
done  out  1  one-clk pulse at block end
underrun  out  1  sticky; data needed while din_valid=0

Behaviour:
- Reset: tape_out=0, busy=0, done=0, din_ready=0, underrun=0, state IDLE. The reset value of every counter is 0.
- Pulse: a down-counter loaded with length-1 decrements on clk where ce=1 and motor=1. At 0 with ce=1, tape_out toggles, and the next pulse loads on that same clk. A pulse of length L therefore spans exactly L ce ticks. A length of 0 is treated as 1.
- States: IDLE -> PILOT -> SYNC1 -> SYNC2 -> DATA -> TAIL -> IDLE.
- IDLE: start=1 latches all *_t fields and pilot_len, sets busy=1 and underrun=0, and moves to PILOT. If pilot_len=0, it moves to SYNC1 instead. start is ignored while busy=1.
- PILOT: emits pilot_len pulses of pilot_t, then goes to SYNC1.
- SYNC1 and SYNC2: one pulse each, of sync1_t and sync2_t respectively.
- DATA: bits are sent MSB first. Each bit is two pulses of zero_t or one_t.
- Byte fetch: the byte is fetched when a new byte is needed, on entry to DATA or after bit 0 of the previous byte.
  - din_ready=1 for exactly one clk, when din_valid=1. The byte and din_last are captured in that clk.
  - If din_valid=0 when a byte is needed: underrun=1, the counter holds, tape_out holds, and fetch waits until din_valid goes high.
- After both pulses of bit 0 of a byte captured with din_last=1, the state moves to TAIL.
- TAIL: tape_out is held for TAIL_TICKS ce ticks (frozen while motor=0). Then: done=1 for one clk, busy=0, state IDLE.
- motor=0: all counters and the state freeze and tape_out holds. din_ready may still complete a pending fetch. Generation resumes exactly where it stopped.
- start coincident with done: ignored. Start is accepted from the clk after done.
- Reset mid-block: returns to the reset state immediately. In-flight data is discarded.
- tape_out is registered. The first toggle occurs pilot_t ce ticks after start, with motor=1 and ce continuous.

Decomposition:
- Package tape_pkg:
  - state enum (IDLE, PILOT, SYNC1, SYNC2, DATA, TAIL)
  - TW
  - default CPC timings at 4 MHz: pilot 2000, sync 600, zero 667, one 1333 ticks; pilot_len 4096
- Sub-module tape_pulse_timer: load value, ce/motor gating, expiry strobe, level toggle. The FSM stays in the top module.

Test Plan:
- pilot_len=4, pilot_t=10, sync 3/5, one byte 0xA5 last, zero_t=2, one_t=4, ce continuous. Required response:
  - Edge intervals are 10,10,10,10,3,5, then bits 1,0,1,0,0,1,0,1 as pairs 4,4,2,2,4,4,2,2,2,2,4,4,2,2,4,4.
  - done fires after TAIL_TICKS.
- Motor dropped for 50 clks in mid-pilot -> no edge in the gap; the interval containing the gap equals 10 + 50 ce ticks; the total edge count is unchanged.
- din_valid low for 20 clks at the second-byte fetch -> underrun=1; tape_out is stable through the gap; the second byte is emitted correctly afterwards; underrun clears on the next start.
- start pulsed while busy, and again in the done clk -> both are ignored; a start one clk later begins a block with freshly latched timings.
- reset_n asserted mid-DATA -> asynchronous: tape_out=0, busy=0, din_ready=0 immediately; a subsequent start runs a full block.
- pilot_len=0, zero_t=0 -> the first edge is after sync1_t; zero bits produce 1-tick pulses.
